wave_cfg_ctrl: RTL and testbench



---
 rtl/wavegen_pkg.sv | 21 ++
 rtl/wave_cfg_ctrl_if.sv | 23 ++
 rtl/wave_tick_div.sv | 33 +++
 rtl/wave_cfg_ctrl.sv | 144 ++++++++++++++
 tb/tb_wave_cfg_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// Shared constants and state encoding for the triangle-wave configuration controller.
package wavegen_pkg;

  localparam logic [1:0] ADDR_P2P  = 2'd0;
  localparam logic [1:0] ADDR_BIAS = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int unsigned CTRL_RUN   = 0;
  localparam int unsigned CTRL_APPLY = 1;

  localparam int unsigned DEF_P2P  = 1024;
  localparam int unsigned DEF_BIAS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/wave_cfg_ctrl_if.sv
// Host-side valid/ready configuration write port.
interface wave_cfg_ctrl_if;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/wave_tick_div.sv
// Rate divider: one-cycle tick every div+1 cycles while enabled; restart or disable zeroes the count.
module wave_tick_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || restart || (cnt_q == div)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_cfg_ctrl.sv
// Shadow/live configuration for the triangle generator: commits at a trough (or when stopped
// or timed out), clamps bias so the wave stays in range, and paces the generator.
module wave_cfg_ctrl #(
  parameter int unsigned AMP_W    = 11,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DEF_P2P  = wavegen_pkg::DEF_P2P,
  parameter int unsigned DEF_BIAS = wavegen_pkg::DEF_BIAS,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  wave_cfg_ctrl_if.slave    cfg,
  input  logic              at_trough,
  output logic              wave_tick,
  output logic [AMP_W-1:0]  p2p_out,
  output logic [AMP_W-1:0]  bias_out,
  output logic              running,
  output logic              pending,
  output logic              clamped
);

  import wavegen_pkg::*;

  localparam int unsigned     TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_e           state_q;
  logic [AMP_W-1:0] sh_p2p_q;
  logic [AMP_W-1:0] sh_bias_q;
  logic [DIV_W-1:0] sh_div_q;
  logic             sh_run_q;
  logic [AMP_W-1:0] p2p_q;
  logic [AMP_W-1:0] bias_q;
  logic [DIV_W-1:0] div_q;
  logic             run_q;
  logic             pend_q;
  logic             clamp_q;
  logic             ready_q;
  logic [TO_W-1:0]  to_q;

  logic             take;
  logic             apply_wr;
  logic             commit_go;
  logic [AMP_W-1:0] half_d;
  logic [AMP_W:0]   upper_sum_d;
  logic [AMP_W-1:0] bias_d;
  logic             clamp_d;

  assign cfg.cfg_ready = ready_q;
  assign p2p_out       = p2p_q;
  assign bias_out      = bias_q;
  assign running       = run_q;
  assign pending       = pend_q;
  assign clamped       = clamp_q;

  assign take      = cfg.cfg_valid && ready_q;
  assign apply_wr  = take && (cfg.cfg_addr == ADDR_CTRL) && cfg.cfg_data[CTRL_APPLY];
  assign commit_go = (run_q && wave_tick && at_trough) || !run_q || (to_q == TO_MAX);

  // Keep bias within [half, 2^AMP_W-1-half]; a carry out of bias+half means the peak overflows.
  always_comb begin
    half_d      = sh_p2p_q >> 1;
    upper_sum_d = {1'b0, sh_bias_q} + {1'b0, half_d};
    bias_d      = sh_bias_q;
    clamp_d     = 1'b0;
    if (sh_bias_q < half_d) begin
      bias_d  = half_d;
      clamp_d = 1'b1;
    end else if (upper_sum_d[AMP_W]) begin
      bias_d  = {AMP_W{1'b1}} - half_d;
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sh_p2p_q  <= AMP_W'(DEF_P2P);
      sh_bias_q <= AMP_W'(DEF_BIAS);
      sh_div_q  <= '0;
      sh_run_q  <= 1'b0;
      p2p_q     <= AMP_W'(DEF_P2P);
      bias_q    <= AMP_W'(DEF_BIAS);
      div_q     <= '0;
      run_q     <= 1'b0;
      pend_q    <= 1'b0;
      clamp_q   <= 1'b0;
      ready_q   <= 1'b1;
      to_q      <= '0;
    end else begin
      if (take) begin
        case (cfg.cfg_addr)
          ADDR_P2P:  sh_p2p_q  <= cfg.cfg_data[AMP_W-1:0];
          ADDR_BIAS: sh_bias_q <= cfg.cfg_data[AMP_W-1:0];
          ADDR_DIV:  sh_div_q  <= cfg.cfg_data[DIV_W-1:0];
          default:   sh_run_q  <= cfg.cfg_data[CTRL_RUN];
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (apply_wr) begin
            state_q <= ST_PENDING;
            pend_q  <= 1'b1;
            to_q    <= '0;
          end
        end
        // A further apply while waiting merges: shadows are only sampled in ST_COMMIT.
        ST_PENDING: begin
          if (wave_tick && (to_q != TO_MAX)) begin
            to_q <= to_q + 1'b1;
          end
          if (commit_go) begin
            state_q <= ST_COMMIT;
            ready_q <= 1'b0;
          end
        end
        ST_COMMIT: begin
          p2p_q   <= sh_p2p_q;
          bias_q  <= bias_d;
          clamp_q <= clamp_d;
          run_q   <= sh_run_q;
          div_q   <= sh_div_q;
          pend_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  wave_tick_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .en      (run_q),
    .div     (div_q),
    .restart (state_q == ST_COMMIT),
    .tick    (wave_tick)
  );

endmodule

// File: tb/tb_wave_cfg_ctrl.sv
// Directed bench for wave_cfg_ctrl: default-timeout instance plus a TIMEOUT=8 instance.
module tb_wave_cfg_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_cfg_ctrl_if bus0 ();
  wave_cfg_ctrl_if bus8 ();

  logic        trough0, trough8;
  logic        tick0, run0, pend0, clamp0;
  logic        tick8, run8, pend8, clamp8;
  logic [10:0] p2p0, bias0, p2p8, bias8;

  int errors = 0;
  int checks = 0;

  wave_cfg_ctrl dut0 (
    .clk(clk), .rst(rst), .cfg(bus0), .at_trough(trough0), .wave_tick(tick0),
    .p2p_out(p2p0), .bias_out(bias0), .running(run0), .pending(pend0), .clamped(clamp0)
  );

  wave_cfg_ctrl #(.TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst), .cfg(bus8), .at_trough(trough8), .wave_tick(tick8),
    .p2p_out(p2p8), .bias_out(bias8), .running(run8), .pending(pend8), .clamped(clamp8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; the write is taken on the posedge in between.
  task automatic wr(input bit sel, input logic [1:0] a, input logic [15:0] d);
    int n;
    n = 0;
    if (!sel) begin
      bus0.cfg_valid = 1'b1; bus0.cfg_addr = a; bus0.cfg_data = d;
    end else begin
      bus8.cfg_valid = 1'b1; bus8.cfg_addr = a; bus8.cfg_data = d;
    end
    while (((sel ? bus8.cfg_ready : bus0.cfg_ready) !== 1'b1) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("wr_ready_wait", 32'(sel ? bus8.cfg_ready : bus0.cfg_ready), 32'd1);
    @(negedge clk);
    bus0.cfg_valid = 1'b0;
    bus8.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((pend0 !== 1'b0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(pend0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [11:0] pat;
    int          bad;
    int          ticks;
    int          first_idle;
    logic [10:0] p2p_k9;

    rst = 1'b1;
    trough0 = 1'b0; trough8 = 1'b0;
    bus0.cfg_valid = 1'b0; bus0.cfg_addr = '0; bus0.cfg_data = '0;
    bus8.cfg_valid = 1'b0; bus8.cfg_addr = '0; bus8.cfg_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, then 10 idle cycles without any tick.
    chk("rst_p2p", 32'(p2p0), 32'd1024);
    chk("rst_bias", 32'(bias0), 32'd1024);
    chk("rst_running", 32'(run0), 32'd0);
    chk("rst_pending", 32'(pend0), 32'd0);
    chk("rst_clamped", 32'(clamp0), 32'd0);
    chk("rst_ready", 32'(bus0.cfg_ready), 32'd1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      if (tick0 === 1'b1) ticks++;
      @(negedge clk);
    end
    chk("idle_no_tick", 32'(ticks), 32'd0);
    chk("idle_p2p", 32'(p2p0), 32'd1024);

    // Stopped apply: PENDING, COMMIT, then live; tick every 4 cycles starting 4 after COMMIT.
    wr(0, 2'd2, 16'd3);
    wr(0, 2'd3, 16'b11);
    chk("stop_apply_pending", 32'(pend0), 32'd1);
    chk("stop_apply_notyet", 32'(run0), 32'd0);
    @(negedge clk);
    chk("commit_ready_low", 32'(bus0.cfg_ready), 32'd0);
    chk("commit_pending", 32'(pend0), 32'd1);
    @(negedge clk);
    chk("stop_apply_running", 32'(run0), 32'd1);
    chk("stop_apply_done", 32'(pend0), 32'd0);
    chk("stop_apply_ready", 32'(bus0.cfg_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      pat[i] = tick0;
      @(negedge clk);
    end
    chk("div3_tick_pattern", 32'(pat), 32'h888);

    // Switch to div=0 through a trough-gated commit.
    trough0 = 1'b1;
    wr(0, 2'd2, 16'd0);
    wr(0, 2'd3, 16'b11);
    wait_idle("div0_commit_idle");
    trough0 = 1'b0;

    // Trough-gated commit with a merged second apply; the latest bias wins.
    wr(0, 2'd0, 16'd200);
    wr(0, 2'd1, 16'd400);
    wr(0, 2'd3, 16'b11);
    wr(0, 2'd1, 16'd500);
    wr(0, 2'd3, 16'b11);
    bad = 0;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      if ((p2p0 !== 11'd1024) || (bias0 !== 11'd1024) || (pend0 !== 1'b1)) bad++;
      if (tick0 === 1'b1) ticks++;
      @(negedge clk);
    end
    chk("hold_live_until_trough", 32'(bad), 32'd0);
    chk("div0_tick_every_cycle", 32'(ticks), 32'd50);
    chk("tick_at_trough_pulse", 32'(tick0), 32'd1);
    trough0 = 1'b1;
    @(negedge clk);
    trough0 = 1'b0;
    chk("commit_cycle_p2p_old", 32'(p2p0), 32'd1024);
    chk("commit_cycle_pending", 32'(pend0), 32'd1);
    @(negedge clk);
    chk("trough_p2p", 32'(p2p0), 32'd200);
    chk("trough_bias_merged", 32'(bias0), 32'd500);
    chk("trough_pending_fall", 32'(pend0), 32'd0);
    chk("trough_clamped", 32'(clamp0), 32'd0);

    // Clamp cases, trough held high so each commit follows the next tick.
    trough0 = 1'b1;
    wr(0, 2'd0, 16'd600);
    wr(0, 2'd1, 16'd100);
    wr(0, 2'd3, 16'b11);
    wait_idle("clamp_lo_idle");
    chk("clamp_lo_bias", 32'(bias0), 32'd300);
    chk("clamp_lo_flag", 32'(clamp0), 32'd1);
    wr(0, 2'd1, 16'd2000);
    wr(0, 2'd3, 16'b11);
    wait_idle("clamp_hi_idle");
    chk("clamp_hi_bias", 32'(bias0), 32'd1747);
    chk("clamp_hi_flag", 32'(clamp0), 32'd1);
    wr(0, 2'd1, 16'd1000);
    wr(0, 2'd3, 16'b11);
    wait_idle("clamp_none_idle");
    chk("clamp_none_bias", 32'(bias0), 32'd1000);
    chk("clamp_none_flag", 32'(clamp0), 32'd0);
    wr(0, 2'd0, 16'd2047);
    wr(0, 2'd1, 16'd1024);
    wr(0, 2'd3, 16'b11);
    wait_idle("edge_fit_idle");
    chk("edge_fit_bias", 32'(bias0), 32'd1024);
    chk("edge_fit_flag", 32'(clamp0), 32'd0);
    wr(0, 2'd1, 16'd1025);
    wr(0, 2'd3, 16'b11);
    wait_idle("edge_over_idle");
    chk("edge_over_bias", 32'(bias0), 32'd1024);
    chk("edge_over_flag", 32'(clamp0), 32'd1);
    wr(0, 2'd0, 16'd0);
    wr(0, 2'd1, 16'd2047);
    wr(0, 2'd3, 16'b11);
    wait_idle("p2p0_idle");
    chk("p2p0_pass", 32'(p2p0), 32'd0);
    chk("p2p0_bias_max", 32'(bias0), 32'd2047);
    chk("p2p0_flag", 32'(clamp0), 32'd0);
    trough0 = 1'b0;

    // TIMEOUT=8 instance: start it running at div=0, then apply with no trough.
    wr(1, 2'd3, 16'b11);
    repeat (2) @(negedge clk);
    chk("to8_running", 32'(run8), 32'd1);
    wr(1, 2'd0, 16'd300);
    wr(1, 2'd3, 16'b11);
    first_idle = -1;
    p2p_k9 = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 9) p2p_k9 = p2p8;
      if ((first_idle < 0) && (pend8 === 1'b0)) first_idle = k;
      @(negedge clk);
    end
    chk("to8_commit_cycle", 32'(first_idle), 32'd10);
    chk("to8_p2p_before", 32'(p2p_k9), 32'd1024);
    chk("to8_p2p_after", 32'(p2p8), 32'd300);

    // Reset while PENDING discards the commit and the shadows.
    wr(0, 2'd0, 16'd100);
    wr(0, 2'd1, 16'd900);
    wr(0, 2'd3, 16'b11);
    chk("prerst_pending", 32'(pend0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pending", 32'(pend0), 32'd0);
    chk("midrst_p2p", 32'(p2p0), 32'd1024);
    chk("midrst_bias", 32'(bias0), 32'd1024);
    chk("midrst_running", 32'(run0), 32'd0);
    chk("midrst_clamped", 32'(clamp0), 32'd0);
    trough0 = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ((p2p0 !== 11'd1024) || (pend0 !== 1'b0)) bad++;
    end
    chk("postrst_trough_no_commit", 32'(bad), 32'd0);
    trough0 = 1'b0;
    wr(0, 2'd3, 16'b10);
    wait_idle("postrst_apply_idle");
    chk("postrst_apply_p2p", 32'(p2p0), 32'd1024);
    chk("postrst_apply_bias", 32'(bias0), 32'd1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
